bnn_param_loader: RTL and testbench
===================================

// Module: bnn_param_loader
// PURPOSE
//  Host-side driver for the BNN serial parameter chain. It takes parameter bytes over a
//  valid/ready stream and serializes them onto the chain head (param_out -> first neuron
//  param_in), qualifying each bit with setup. It also captures the bits leaving the chain
//  tail (chain_in), which are the previous chain contents, and returns them as bytes.
//  The parameter image can therefore be loaded and read back in one pass.
// PARAMETERS
//  CHAIN_BITS  96  total bits in the parameter chain (all neurons concatenated)
//  CNT_W       $clog2(CHAIN_BITS+1)  bit-counter width (derived, do not override)
// PORTS
//  clk         in   1  single clock, rising edge; same clock as the neuron chain
//  rst_n       in   1  asynchronous active-low reset
//  start       in   1  1-cycle request to begin a load; sampled only in IDLE
//  byte_in     in   8  parameter byte; bit 7 is shifted first
//  byte_valid  in   1  byte_in is valid
//  byte_ready  out  1  loader accepts byte_in this cycle (transfer = valid & ready)
//  setup       out  1  chain shift enable; high only on cycles that carry a real bit
//  param_out   out  1  serial bit to the chain head
//  chain_in    in   1  serial bit from the chain tail (last neuron param_out)
//  rb_byte     out  8  readback byte, first captured bit in bit 7
//  rb_valid    out  1  1-cycle pulse: rb_byte is valid
//  busy        out  1  high from the cycle after start is accepted until done
//  done        out  1  1-cycle pulse after the final shift edge
// BEHAVIOUR
//  Reset values: all outputs are 0 and the FSM is in IDLE. Reset is async assert and
//   sync deassert. A reset mid-load leaves the chain partially loaded; the host must reload.
//  FSM states IDLE, WAIT_BYTE, SHIFT and DONE:
//   IDLE: start=1 -> WAIT_BYTE and bits_left<=CHAIN_BITS. start while not IDLE is ignored.
//   WAIT_BYTE: byte_ready=1. On transfer, load shift reg and bit_idx<=0 -> SHIFT.
//   SHIFT: setup=1 and param_out=shreg[7]. Each edge shifts shreg left, bit_idx++, bits_left--.
//    - bits_left==1 at the edge -> DONE.
//    - else bit_idx==7 at the edge: a transfer this cycle reloads shreg and stays in SHIFT
//      (back-to-back bytes, no bubble). No transfer -> WAIT_BYTE.
//   DONE: done=1 for exactly 1 cycle -> IDLE. busy=0 in IDLE only.
//  byte_ready = WAIT_BYTE | (SHIFT & bit_idx==7 & bits_left>1).
//  setup and param_out are decoded from registers only, with no combinational path from
//   inputs. Setup drops during byte starvation. The chain shifts only while setup=1, so no
//   bits are lost or duplicated.
//  Exactly CHAIN_BITS cycles have setup=1 per load. The first bit sent ends at the chain tail.
//  Partial final byte (CHAIN_BITS%8!=0): only its upper CHAIN_BITS%8 bits are sent. The
//   rest are discarded, and no further byte is requested.
//  Readback: on every SHIFT edge, chain_in is shifted into rb_shreg (MSB-first).
//   - After 8 captured bits, rb_byte<=rb_shreg and rb_valid=1 on the next cycle.
//   - On the final bit of a partial byte, rb_byte holds the captured bits left-justified and
//     zero-padded. rb_valid then pulses in the same cycle as done.
//   - rb_valid has no back-pressure; the host must take it when it pulses.
//  Byte count per load is ceil(CHAIN_BITS/8). Extra byte_valid after the last byte is not accepted.
// TESTING
//  1. Chain model of 96 FFs, back-to-back bytes 0xA5,0x3C,... (12 total)
//     -> 96 consecutive setup cycles and done 97 cycles after the first transfer.
//     The model contents equal the stream, and readback matches the pre-load pattern.
//  2. byte_valid low for 5 cycles after byte 3 -> setup low 5+ cycles, no chain shift.
//     The final chain image is identical to test 1.
//  3. CHAIN_BITS=12, bytes 0xF0,0xB7 -> bits 1111_0000_1011 shifted and 0111 dropped.
//     Exactly 2 transfers, and the last rb_byte is zero-padded in the low 4 bits.
//  4. start pulsed in SHIFT and DONE -> ignored. rst_n low in the middle of byte 5
//     -> setup, busy and byte_ready go to 0 immediately. The next start then reloads fully.
//  5. Load twice -> the second pass's rb_byte sequence equals the first pass's byte_in sequence.
//  6. byte_valid held high with no start -> byte_ready=0 and setup=0 throughout.

Source files
------------

// File: rtl/bnn_param_loader.sv
// Host-side loader for the BNN serial parameter chain: serializes bytes onto the chain head
// and returns the bits leaving the chain tail as readback bytes, in a single pass.
module bnn_param_loader #(
    parameter int CHAIN_BITS = 96,
    parameter int CNT_W      = $clog2(CHAIN_BITS + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       setup,
    output logic       param_out,
    input  logic       chain_in,
    output logic [7:0] rb_byte,
    output logic       rb_valid,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, WAIT_BYTE, SHIFT, DONE} state_t;

    state_t           state;
    logic [7:0]       shreg;
    logic [7:0]       rb_shreg;
    logic [2:0]       bit_idx;
    logic [CNT_W-1:0] bits_left;
    logic             last_bit;
    logic             transfer;
    logic [7:0]       rb_next;

    assign last_bit   = (bits_left == CNT_W'(1));
    assign byte_ready = (state == WAIT_BYTE) ||
                        ((state == SHIFT) && (bit_idx == 3'd7) && (bits_left > CNT_W'(1)));
    assign transfer   = byte_valid && byte_ready;
    assign rb_next    = {rb_shreg[6:0], chain_in};

    // All chain-facing outputs decode the state register; no input reaches them combinationally.
    assign setup     = (state == SHIFT);
    assign param_out = setup && shreg[7];
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= 8'd0;
            rb_shreg  <= 8'd0;
            bit_idx   <= 3'd0;
            bits_left <= '0;
            rb_byte   <= 8'd0;
            rb_valid  <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= WAIT_BYTE;
                        bits_left <= CNT_W'(CHAIN_BITS);
                        bit_idx   <= 3'd0;
                    end
                end
                WAIT_BYTE: begin
                    if (transfer) begin
                        shreg   <= byte_in;
                        bit_idx <= 3'd0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg     <= {shreg[6:0], 1'b0};
                    bit_idx   <= bit_idx + 3'd1;
                    bits_left <= bits_left - CNT_W'(1);
                    rb_shreg  <= rb_next;
                    if (last_bit) begin
                        // Left-justify a short final readback byte, zero-padding the low bits.
                        rb_byte  <= rb_next << (3'd7 - bit_idx);
                        rb_valid <= 1'b1;
                        state    <= DONE;
                    end else if (bit_idx == 3'd7) begin
                        rb_byte  <= rb_next;
                        rb_valid <= 1'b1;
                        if (transfer) begin
                            shreg <= byte_in;
                        end else begin
                            state <= WAIT_BYTE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_param_loader.sv
// Bench for bnn_param_loader: a 96-bit and a 12-bit instance, each driving a behavioural
// chain of flops, checked against bit-image expectations derived from the byte streams.
module tb_bnn_param_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- 96-bit instance ----------------
    logic       start_a, byte_valid_a, byte_ready_a, setup_a, param_out_a, chain_in_a;
    logic       rb_valid_a, busy_a, done_a;
    logic [7:0] byte_in_a, rb_byte_a;

    bnn_param_loader #(.CHAIN_BITS(96)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .byte_in(byte_in_a),
        .byte_valid(byte_valid_a), .byte_ready(byte_ready_a), .setup(setup_a),
        .param_out(param_out_a), .chain_in(chain_in_a), .rb_byte(rb_byte_a),
        .rb_valid(rb_valid_a), .busy(busy_a), .done(done_a)
    );

    // ---------------- 12-bit instance ----------------
    logic       start_b, byte_valid_b, byte_ready_b, setup_b, param_out_b, chain_in_b;
    logic       rb_valid_b, busy_b, done_b;
    logic [7:0] byte_in_b, rb_byte_b;

    bnn_param_loader #(.CHAIN_BITS(12)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .byte_in(byte_in_b),
        .byte_valid(byte_valid_b), .byte_ready(byte_ready_b), .setup(setup_b),
        .param_out(param_out_b), .chain_in(chain_in_b), .rb_byte(rb_byte_b),
        .rb_valid(rb_valid_b), .busy(busy_b), .done(done_b)
    );

    // Chain models: plain shift registers that move only while setup is high; never reset.
    logic        preset_en = 1'b0;
    logic [95:0] preset_a;
    logic [11:0] preset_b;
    logic [95:0] chain_a;
    logic [11:0] chain_b;

    always @(posedge clk) begin
        if (preset_en) chain_a <= preset_a;
        else if (setup_a) chain_a <= {chain_a[94:0], param_out_a};
    end
    always @(posedge clk) begin
        if (preset_en) chain_b <= preset_b;
        else if (setup_b) chain_b <= {chain_b[10:0], param_out_b};
    end
    assign chain_in_a = chain_a[95];
    assign chain_in_b = chain_b[11];

    // Monitors sample mid-cycle.
    int         setup_n_a = 0, xfer_n_a = 0, ready_n_a = 0, rb_n_a = 0, done_cyc_a = 0;
    int         xfer_cyc_a[0:511];
    logic [7:0] rb_log_a[0:511];
    int         setup_n_b = 0, xfer_n_b = 0, rb_n_b = 0, rbdone_n_b = 0;
    logic [7:0] rb_log_b[0:63];

    always @(negedge clk) begin
        if (setup_a) setup_n_a = setup_n_a + 1;
        if (byte_ready_a) ready_n_a = ready_n_a + 1;
        if (byte_valid_a && byte_ready_a) begin
            xfer_cyc_a[xfer_n_a & 511] = cyc;
            xfer_n_a = xfer_n_a + 1;
        end
        if (rb_valid_a) begin
            rb_log_a[rb_n_a & 511] = rb_byte_a;
            rb_n_a = rb_n_a + 1;
        end
        if (done_a) done_cyc_a = cyc;
    end
    always @(negedge clk) begin
        if (setup_b) setup_n_b = setup_n_b + 1;
        if (byte_valid_b && byte_ready_b) xfer_n_b = xfer_n_b + 1;
        if (rb_valid_b) begin
            rb_log_b[rb_n_b & 63] = rb_byte_b;
            rb_n_b = rb_n_b + 1;
        end
        if (rb_valid_b && done_b) rbdone_n_b = rbdone_n_b + 1;
    end

    logic [7:0]  stim[0:11];
    logic [95:0] prev_img;
    int          snap_setup, snap_xfer, snap_rb, snap_ready;
    bit          load_ok;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic new_stim();
        for (int i = 0; i < 12; i++) stim[i] = 8'($urandom);
    endtask

    // The first streamed bit lands at the tail, so the image is the bytes concatenated in order.
    function automatic logic [95:0] stim_img();
        logic [95:0] img = '0;
        for (int i = 0; i < 12; i++) img = {img[87:0], stim[i]};
        return img;
    endfunction

    function automatic logic [95:0] rb_img(input int base);
        logic [95:0] img = '0;
        for (int i = 0; i < 12; i++) img = {img[87:0], rb_log_a[(base + i) & 511]};
        return img;
    endfunction

    task automatic load_a(input int gap_after, input int gap_len, input bit noise,
                          input int abort_at);
        int budget;
        load_ok    = 1'b1;
        snap_setup = setup_n_a;
        snap_xfer  = xfer_n_a;
        snap_rb    = rb_n_a;
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 if (!noise) start_a = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == gap_after) begin
                byte_valid_a = 1'b0;
                repeat (gap_len) @(posedge clk);
                #1;
            end
            byte_in_a    = stim[i];
            byte_valid_a = 1'b1;
            budget = 0;
            @(negedge clk);
            while (!byte_ready_a && budget < 200) begin
                budget++;
                @(negedge clk);
            end
            if (!byte_ready_a) begin
                chk("byte_ready_timeout", 96'(i), 96'd99);
                load_ok = 1'b0;
                byte_valid_a = 1'b0;
                start_a = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (i == abort_at) begin
                byte_valid_a = 1'b0;
                repeat (3) @(posedge clk);
                #1 chk("pre_abort_setup", 96'(setup_a), 96'd1);
                #1 rst_n = 1'b0;
                #1 chk("abort_outputs", {setup_a, busy_a, byte_ready_a}, 96'd0);
                start_a = 1'b0;
                @(posedge clk); #1 rst_n = 1'b1;
                return;
            end
        end
        byte_in_a = 8'hEE;   // stays valid past the last byte; must not be taken
        budget = 0;
        @(negedge clk);
        while (!done_a && budget < 400) begin
            budget++;
            @(negedge clk);
        end
        start_a = 1'b0;
        if (!done_a) begin
            chk("done_timeout", 96'(budget), 96'd0);
            load_ok = 1'b0;
        end
        @(posedge clk); #1 byte_valid_a = 1'b0;
    endtask

    task automatic check_load_a(input string tag, input bit check_rb);
        logic [95:0] img = stim_img();
        chk({tag, "_setup_cycles"}, 96'(setup_n_a - snap_setup), 96'd96);
        chk({tag, "_transfers"}, 96'(xfer_n_a - snap_xfer), 96'd12);
        chk({tag, "_chain_image"}, chain_a, img);
        if (check_rb) begin
            chk({tag, "_rb_count"}, 96'(rb_n_a - snap_rb), 96'd12);
            chk({tag, "_readback"}, rb_img(snap_rb), prev_img);
        end
        prev_img = img;
    endtask

    task automatic wait_ready_b();
        int budget = 0;
        @(negedge clk);
        while (!byte_ready_b && budget < 100) begin
            budget++;
            @(negedge clk);
        end
        if (!byte_ready_b) chk("b_ready_timeout", 96'(budget), 96'd0);
        @(posedge clk); #1;
    endtask

    task automatic load_b(input logic [11:0] prev, input string tag);
        int sb = setup_n_b, xb = xfer_n_b, rbb = rb_n_b, rdb = rbdone_n_b, budget = 0;
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        byte_in_b = 8'hF0; byte_valid_b = 1'b1;
        wait_ready_b();
        byte_in_b = 8'hB7;
        wait_ready_b();
        byte_in_b = 8'hEE;
        @(negedge clk);
        while (!done_b && budget < 100) begin
            budget++;
            @(negedge clk);
        end
        if (!done_b) chk({tag, "_done_timeout"}, 96'(budget), 96'd0);
        @(posedge clk); #1 byte_valid_b = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_setup_cycles"}, 96'(setup_n_b - sb), 96'd12);
        chk({tag, "_transfers"}, 96'(xfer_n_b - xb), 96'd2);
        chk({tag, "_chain_image"}, 96'(chain_b), 96'h0F0B);
        chk({tag, "_rb_count"}, 96'(rb_n_b - rbb), 96'd2);
        chk({tag, "_rb_byte0"}, 96'(rb_log_b[rbb & 63]), 96'(prev[11:4]));
        chk({tag, "_rb_byte1_padded"}, 96'(rb_log_b[(rbb + 1) & 63]), 96'({prev[3:0], 4'h0}));
        chk({tag, "_rb_with_done"}, 96'(rbdone_n_b - rdb), 96'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; byte_valid_a = 1'b0; byte_in_a = 8'h00;
        start_b = 1'b0; byte_valid_b = 1'b0; byte_in_b = 8'h00;
        preset_a = {$urandom, $urandom, $urandom};
        preset_b = 12'($urandom);
        preset_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 preset_en = 1'b0;
        chk("reset_outputs_a", {rb_byte_a, byte_ready_a, setup_a, param_out_a, rb_valid_a,
                                busy_a, done_a}, 96'd0);
        chk("reset_outputs_b", {rb_byte_b, byte_ready_b, setup_b, busy_b, done_b}, 96'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Valid held high without start: nothing accepted, nothing shifted.
        snap_setup = setup_n_a; snap_ready = ready_n_a;
        byte_in_a = 8'h5A; byte_valid_a = 1'b1;
        repeat (20) @(posedge clk);
        #1 byte_valid_a = 1'b0;
        chk("idle_ready_cycles", 96'(ready_n_a - snap_ready), 96'd0);
        chk("idle_setup_cycles", 96'(setup_n_a - snap_setup), 96'd0);
        chk("idle_busy", 96'(busy_a), 96'd0);

        // Back-to-back load; readback must return the preset chain contents.
        prev_img = preset_a;
        new_stim();
        stim[0] = 8'hA5; stim[1] = 8'h3C;
        load_a(-1, 0, 1'b0, -1);
        if (load_ok) chk("b2b_done_latency", 96'(done_cyc_a - xfer_cyc_a[snap_xfer & 511]), 96'd97);
        check_load_a("b2b", 1'b1);

        // Same bytes with starvation after byte 3.
        load_a(3, 13, 1'b0, -1);
        chk("gap_setup_low_ge5",
            96'((done_cyc_a - xfer_cyc_a[snap_xfer & 511] - 1 - 96) >= 5), 96'd1);
        check_load_a("gap", 1'b1);

        // start held high through WAIT_BYTE/SHIFT/DONE must not disturb the load.
        new_stim();
        load_a(-1, 0, 1'b1, -1);
        check_load_a("noise", 1'b1);
        snap_xfer = xfer_n_a;
        repeat (4) @(posedge clk);
        #1 chk("noise_back_idle", {busy_a, setup_a}, 96'd0);

        // Reset during byte 5, then a full reload.
        new_stim();
        load_a(-1, 0, 1'b0, 4);
        chk("abort_idle_after", {busy_a, setup_a, byte_ready_a}, 96'd0);
        new_stim();
        load_a(-1, 0, 1'b0, -1);
        check_load_a("reload", 1'b0);

        // Read back while loading: returns the previous pass's byte stream.
        new_stim();
        load_a(-1, 0, 1'b0, -1);
        check_load_a("readback", 1'b1);

        // 12-bit chain: partial final byte.
        load_b(preset_b, "short1");
        load_b(12'hF0B, "short2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
